// File: rtl/draw_scope_trace_if.sv
// VGA timing/colour bundle passed through the oscilloscope overlay.
// Modport "in" is the receiving side, modport "out" the driving side.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_scope_trace.sv
// Double-buffered oscilloscope trace overlay: samples stream into a back bank while
// the front bank is drawn as vertically filled traces over a grid and border.
module draw_scope_trace #(
  parameter int N_CH  = 2,
  parameter int DEPTH = 256,
  parameter int X0    = 100,
  parameter int Y0    = 100,
  parameter int GRID  = 32
) (
  input  logic              clk,
  input  logic              rst,
  vga_if.in                 in,
  vga_if.out                out,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [8*N_CH-1:0] s_data,
  input  logic              freeze,
  output logic              frame_swapped
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GRID);
  localparam logic signed [11:0] X0S    = 12'(X0);
  localparam logic signed [11:0] Y0S    = 12'(Y0);
  localparam logic signed [11:0] XL     = 12'(X0 - 1);
  localparam logic signed [11:0] XEND   = 12'(X0 + DEPTH);
  localparam logic signed [11:0] YT     = 12'(Y0 - 1);
  localparam logic signed [11:0] YB2    = 12'(Y0 + 256);
  localparam logic signed [11:0] YBOT   = 12'(Y0 + 255);
  localparam logic signed [11:0] DEPTHS = 12'(DEPTH);
  localparam logic [11:0] CH_COL [4] = '{12'hff0, 12'h0ff, 12'hf0f, 12'h0f0};
  localparam logic [11:0] BORDER_COL = 12'hfa0;
  localparam logic [11:0] GRID_COL   = 12'h444;

  typedef enum logic {FILLING, FULL} fill_state_t;

  fill_state_t       state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic              sel_q, sel_d;
  logic              validTrace_q, validTrace_d;
  logic              frameSwapped_q;
  logic              vblnkPrev_q;
  logic              swap, wrEn, vblnkRise;

  logic [8*N_CH-1:0] mem [2*DEPTH];

  // Stage-0 geometry, computed from the raw input pixel
  logic signed [11:0] hS, vS, xS, yS, rowOff;
  logic               inX0, inY0, border0, grid0;
  logic [AW-1:0]      raddr;

  // Stage 1: timing fields, geometry flags and the two sample columns
  logic [10:0]       vcount1_q, hcount1_q;
  logic              vsync1_q, vblnk1_q, hsync1_q, hblnk1_q;
  logic [11:0]       rgb1_q;
  logic              blank1_q, plot1_q, col01_q, border1_q, grid1_q;
  logic [7:0]        y1_q;
  logic [8*N_CH-1:0] rdata_q, prevData_q;
  logic [11:0]       pix1;

  // Stage 2: registered outputs
  logic [10:0]       vcount2_q, hcount2_q;
  logic              vsync2_q, vblnk2_q, hsync2_q, hblnk2_q;
  logic [11:0]       rgb2_q;

  always_comb begin
    vblnkRise    = in.vblnk && !vblnkPrev_q;
    s_ready      = (state_q == FILLING) && !rst;
    wrEn         = s_valid && s_ready;
    state_d      = state_q;
    wptr_d       = wptr_q;
    sel_d        = sel_q;
    validTrace_d = validTrace_q;
    swap         = 1'b0;
    case (state_q)
      FILLING: begin
        if (wrEn) begin
          if (wptr_q == AW'(DEPTH - 1)) begin
            state_d = FULL;
            wptr_d  = '0;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (vblnkRise && !freeze) begin
          swap         = 1'b1;
          sel_d        = ~sel_q;
          validTrace_d = 1'b1;
          state_d      = FILLING;
        end
      end
      default: state_d = FILLING;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FILLING;
      wptr_q         <= '0;
      sel_q          <= 1'b0;
      validTrace_q   <= 1'b0;
      frameSwapped_q <= 1'b0;
      vblnkPrev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wptr_q         <= wptr_d;
      sel_q          <= sel_d;
      validTrace_q   <= validTrace_d;
      frameSwapped_q <= swap;
      vblnkPrev_q    <= in.vblnk;
    end
  end

  // Sample memory is deliberately not reset; the back bank is the one not displayed.
  always_ff @(posedge clk) begin
    if (wrEn) mem[{~sel_q, wptr_q}] <= s_data;
  end

  // Signed 12-bit geometry so pixels left of / above the plot never wrap into it
  always_comb begin
    hS      = signed'({1'b0, in.hcount});
    vS      = signed'({1'b0, in.vcount});
    xS      = hS - X0S;
    yS      = YBOT - vS;
    rowOff  = vS - Y0S;
    inX0    = (xS >= 12'sd0) && (xS < DEPTHS);
    inY0    = (yS >= 12'sd0) && (yS <= 12'sd255);
    border0 = (((hS == XL) || (hS == XEND)) && (vS >= YT) && (vS <= YB2)) ||
              (((vS == YT) || (vS == YB2)) && (hS >= XL) && (hS <= XEND));
    grid0   = inX0 && inY0 && ((xS[GW-1:0] == '0) || (rowOff[GW-1:0] == '0));
    raddr   = xS[AW-1:0];
  end

  // Lowest channel index is applied last so it wins; blanking overrides all
  always_comb begin
    logic [7:0] cur, prv, lo, hi;
    logic       lit;
    cur  = '0;
    prv  = '0;
    lo   = '0;
    hi   = '0;
    lit  = 1'b0;
    pix1 = rgb1_q;
    if (grid1_q)   pix1 = GRID_COL;
    if (border1_q) pix1 = BORDER_COL;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cur = rdata_q[8*k +: 8];
      prv = prevData_q[8*k +: 8];
      lo  = (cur < prv) ? cur : prv;
      hi  = (cur < prv) ? prv : cur;
      lit = col01_q ? (y1_q == cur) : ((y1_q >= lo) && (y1_q <= hi));
      if (validTrace_q && plot1_q && lit) pix1 = CH_COL[k];
    end
    if (blank1_q) pix1 = 12'h000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcount1_q  <= '0;
      hcount1_q  <= '0;
      vsync1_q   <= 1'b0;
      vblnk1_q   <= 1'b0;
      hsync1_q   <= 1'b0;
      hblnk1_q   <= 1'b0;
      rgb1_q     <= '0;
      blank1_q   <= 1'b0;
      plot1_q    <= 1'b0;
      col01_q    <= 1'b0;
      border1_q  <= 1'b0;
      grid1_q    <= 1'b0;
      y1_q       <= '0;
      rdata_q    <= '0;
      prevData_q <= '0;
      vcount2_q  <= '0;
      hcount2_q  <= '0;
      vsync2_q   <= 1'b0;
      vblnk2_q   <= 1'b0;
      hsync2_q   <= 1'b0;
      hblnk2_q   <= 1'b0;
      rgb2_q     <= '0;
    end else begin
      vcount1_q  <= in.vcount;
      hcount1_q  <= in.hcount;
      vsync1_q   <= in.vsync;
      vblnk1_q   <= in.vblnk;
      hsync1_q   <= in.hsync;
      hblnk1_q   <= in.hblnk;
      rgb1_q     <= in.rgb;
      blank1_q   <= in.hblnk | in.vblnk;
      plot1_q    <= inX0 && inY0;
      col01_q    <= (xS == 12'sd0);
      border1_q  <= border0;
      grid1_q    <= grid0;
      y1_q       <= yS[7:0];
      rdata_q    <= mem[{sel_q, raddr}];
      prevData_q <= rdata_q;
      vcount2_q  <= vcount1_q;
      hcount2_q  <= hcount1_q;
      vsync2_q   <= vsync1_q;
      vblnk2_q   <= vblnk1_q;
      hsync2_q   <= hsync1_q;
      hblnk2_q   <= hblnk1_q;
      rgb2_q     <= pix1;
    end
  end

  assign out.vcount    = vcount2_q;
  assign out.hcount    = hcount2_q;
  assign out.vsync     = vsync2_q;
  assign out.vblnk     = vblnk2_q;
  assign out.hsync     = hsync2_q;
  assign out.hblnk     = hblnk2_q;
  assign out.rgb       = rgb2_q;
  assign frame_swapped = frameSwapped_q;

endmodule

// File: tb/tb_draw_scope_trace.sv
// Directed bench for draw_scope_trace: pass-through timing, static overlay,
// trace fill/priority, freeze behaviour and reset during a fill.
module tb_draw_scope_trace;
  localparam int N_CH  = 2;
  localparam int DEPTH = 64;
  localparam int X0    = 100;
  localparam int Y0    = 100;
  localparam int GRID  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        freeze;
  logic        frame_swapped;

  int errors = 0;
  int checks = 0;

  logic [7:0] ch0Pat [DEPTH];
  logic [7:0] ch1Pat [DEPTH];

  vga_if vin ();
  vga_if vout ();

  draw_scope_trace #(
    .N_CH (N_CH),
    .DEPTH(DEPTH),
    .X0   (X0),
    .Y0   (Y0),
    .GRID (GRID)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (vin),
    .out          (vout),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .freeze       (freeze),
    .frame_swapped(frame_swapped)
  );

  always #5 clk = ~clk;

  task automatic setPixel(input int h, input int v, input logic hb, input logic vb,
                          input logic [11:0] rgb);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = 1'b0;
    vin.vsync  = 1'b0;
    vin.rgb    = rgb;
  endtask

  // Drives column h-1 then h on row v; returns out.rgb belonging to pixel (h,v)
  task automatic probe(input int h, input int v, output logic [11:0] r);
    @(negedge clk) setPixel(h - 1, v, 1'b0, 1'b0, 12'h123);
    @(negedge clk) setPixel(h, v, 1'b0, 1'b0, 12'h123);
    @(negedge clk) setPixel(0, 0, 1'b0, 1'b0, 12'h000);
    @(negedge clk) r = vout.rgb;
  endtask

  task automatic fillBank();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = {ch1Pat[i], ch0Pat[i]};
    end
    @(negedge clk) s_valid = 1'b0;
  endtask

  task automatic writeWords(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 16'(i);
    end
    @(negedge clk) s_valid = 1'b0;
  endtask

  task automatic vblankRise(output int pulses);
    pulses = 0;
    @(negedge clk) vin.vblnk = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (frame_swapped) pulses++;
    end
    vin.vblnk = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    freeze  = 1'b0;
    setPixel(5, 7, 1'b0, 1'b0, 12'hfff);
    vin.hsync = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (vout.rgb !== 12'h000) begin
      errors++; $display("[TB] FAIL reset_rgb got %h want %h", vout.rgb, 12'h000);
    end
    checks++;
    if (vout.hcount !== 11'd0 || vout.hsync !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_timing got h=%0d hs=%b want 0/0", vout.hcount, vout.hsync);
    end
    checks++;
    if (s_ready !== 1'b0 || frame_swapped !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl got rdy=%b fs=%b want 0/0", s_ready, frame_swapped);
    end
    setPixel(0, 0, 1'b0, 1'b0, 12'h000);
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL release_ready got %b want 1", s_ready);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    setPixel(5, 7, 1'b0, 1'b0, 12'h123);
    vin.hsync = 1'b1;
    vin.vsync = 1'b1;
    @(negedge clk);
    setPixel(0, 0, 1'b0, 1'b0, 12'h000);
    checks++;
    if (vout.hcount !== 11'd0) begin
      errors++; $display("[TB] FAIL delay_one_cycle got h=%0d want 0", vout.hcount);
    end
    @(negedge clk);
    checks++;
    if (vout.hcount !== 11'd5 || vout.vcount !== 11'd7 || vout.hsync !== 1'b1 ||
        vout.vsync !== 1'b1 || vout.hblnk !== 1'b0 || vout.vblnk !== 1'b0) begin
      errors++;
      $display("[TB] FAIL delay_timing got h=%0d v=%0d hs=%b vs=%b want 5 7 1 1",
               vout.hcount, vout.vcount, vout.hsync, vout.vsync);
    end
    checks++;
    if (vout.rgb !== 12'h123) begin
      errors++; $display("[TB] FAIL delay_rgb got %h want %h", vout.rgb, 12'h123);
    end
    @(negedge clk) setPixel(5, 7, 1'b1, 1'b0, 12'h123);
    @(negedge clk) setPixel(0, 0, 1'b0, 1'b0, 12'h000);
    @(negedge clk);
    checks++;
    if (vout.rgb !== 12'h000 || vout.hblnk !== 1'b1) begin
      errors++; $display("[TB] FAIL hblank got rgb=%h hb=%b want 000/1", vout.rgb, vout.hblnk);
    end
  endtask

  task automatic test_static_overlay();
    int hv [7][2];
    logic [11:0] exp [7];
    logic [11:0] r;
    hv = '{'{110, 150}, '{132, 150}, '{99, 150}, '{99, 99}, '{164, 150}, '{120, 356}, '{165, 150}};
    exp = '{12'h123, 12'h444, 12'hfa0, 12'hfa0, 12'hfa0, 12'hfa0, 12'h123};
    for (int i = 0; i < 7; i++) begin
      probe(hv[i][0], hv[i][1], r);
      checks++;
      if (r !== exp[i]) begin
        errors++;
        $display("[TB] FAIL static_%0d (%0d,%0d) got %h want %h", i, hv[i][0], hv[i][1], r, exp[i]);
      end
    end
  endtask

  task automatic test_ramp();
    int pulses;
    int hv [5][2];
    logic [11:0] exp [5];
    logic [11:0] r;
    for (int i = 0; i < DEPTH; i++) begin
      ch0Pat[i] = 8'(i);
      ch1Pat[i] = 8'd200;
    end
    fillBank();
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL full_ready got %b want 0", s_ready);
    end
    vblankRise(pulses);
    checks++;
    if (pulses != 1) begin
      errors++; $display("[TB] FAIL ramp_swap got %0d pulses want 1", pulses);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL swap_ready got %b want 1", s_ready);
    end
    hv = '{'{110, 345}, '{110, 340}, '{110, 155}, '{100, 355}, '{100, 354}};
    exp = '{12'hff0, 12'h123, 12'h0ff, 12'hff0, 12'h444};
    for (int i = 0; i < 5; i++) begin
      probe(hv[i][0], hv[i][1], r);
      checks++;
      if (r !== exp[i]) begin
        errors++;
        $display("[TB] FAIL ramp_%0d (%0d,%0d) got %h want %h", i, hv[i][0], hv[i][1], r, exp[i]);
      end
    end
  endtask

  task automatic test_fill_span();
    int pulses;
    int hv [8][2];
    logic [11:0] exp [8];
    logic [11:0] r;
    for (int i = 0; i < DEPTH; i++) begin
      ch0Pat[i] = 8'(i);
      ch1Pat[i] = 8'd200;
    end
    ch0Pat[4] = 8'd20;
    ch0Pat[5] = 8'd60;
    ch0Pat[7] = 8'd100;
    ch1Pat[7] = 8'd100;
    fillBank();
    vblankRise(pulses);
    checks++;
    if (pulses != 1) begin
      errors++; $display("[TB] FAIL span_swap got %0d pulses want 1", pulses);
    end
    hv = '{'{105, 335}, '{105, 295}, '{105, 315}, '{105, 336}, '{105, 294},
           '{106, 325}, '{107, 255}, '{107, 205}};
    exp = '{12'hff0, 12'hff0, 12'hff0, 12'h123, 12'h123, 12'hff0, 12'hff0, 12'h0ff};
    for (int i = 0; i < 8; i++) begin
      probe(hv[i][0], hv[i][1], r);
      checks++;
      if (r !== exp[i]) begin
        errors++;
        $display("[TB] FAIL span_%0d (%0d,%0d) got %h want %h", i, hv[i][0], hv[i][1], r, exp[i]);
      end
    end
  endtask

  task automatic test_freeze();
    int pulses;
    logic [11:0] r;
    for (int i = 0; i < DEPTH; i++) begin
      ch0Pat[i] = 8'd30;
      ch1Pat[i] = 8'd200;
    end
    fillBank();
    freeze = 1'b1;
    for (int n = 0; n < 2; n++) begin
      vblankRise(pulses);
      checks++;
      if (pulses != 0 || s_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL frozen_%0d got pulses=%0d rdy=%b want 0/0", n, pulses, s_ready);
      end
    end
    probe(110, 325, r);
    checks++;
    if (r !== 12'h123) begin
      errors++; $display("[TB] FAIL frozen_pixel got %h want %h", r, 12'h123);
    end
    freeze = 1'b0;
    vblankRise(pulses);
    checks++;
    if (pulses != 1 || s_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL unfreeze_swap got pulses=%0d rdy=%b want 1/1", pulses, s_ready);
    end
    probe(110, 325, r);
    checks++;
    if (r !== 12'hff0) begin
      errors++; $display("[TB] FAIL unfrozen_pixel got %h want %h", r, 12'hff0);
    end
  endtask

  task automatic test_reset_midfill();
    logic [11:0] r;
    writeWords(50);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midfill_reset_ready got %b want 0", s_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midfill_release_ready got %b want 1", s_ready);
    end
    probe(110, 325, r);
    checks++;
    if (r !== 12'h123) begin
      errors++; $display("[TB] FAIL midfill_no_trace got %h want %h", r, 12'h123);
    end
    writeWords(DEPTH - 1);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL almost_full_ready got %b want 1", s_ready);
    end
    writeWords(1);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL refill_full_ready got %b want 0", s_ready);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_static_overlay();
    test_ramp();
    test_fill_span();
    test_freeze();
    test_reset_midfill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/draw_scope_trace.md
DRAW_SCOPE_TRACE -- requirements
Module: draw_scope_trace

Interface
REQ-001 Parameter: N_CH, default 2, number of trace channels (1..4).
REQ-002 Parameter: DEPTH, default 256, samples per channel per trace, power of 2 (64..1024).
REQ-003 Parameter: X0, default 100, hcount of leftmost plot column.
REQ-004 Parameter: Y0, default 100, vcount of top plot row; plot height fixed at 256 rows.
REQ-005 Parameter: GRID, default 32, grid pitch in pixels, power of 2.
REQ-006 Port: clk  in  1  pixel clock; only clock.
REQ-007 Port: rst  in  1  asynchronous, active-high reset.
REQ-008 Port: in  vga_if.in  -  timing/rgb stream: vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0].
REQ-009 Port: out  vga_if.out  -  same fields, delayed 2 cycles, rgb overlaid.
REQ-010 Port: s_valid  in  1  sample word valid.
REQ-011 Port: s_ready  out  1  sample word accepted when s_valid and s_ready both high at posedge clk.
REQ-012 Port: s_data  in  8*N_CH  one 8-bit unsigned sample per channel, channel k at bits [8k+7:8k].
REQ-013 Port: freeze  in  1  when high, buffer swap is inhibited (displayed trace held).
REQ-014 Port: frame_swapped  out  1  one-cycle pulse on each buffer swap.

Function
REQ-015 Two sample banks (front = displayed, back = being filled), each DEPTH x 8*N_CH; bank select bit sel.
REQ-016 Accepted word written to back bank at wptr; wptr increments by 1; write at wptr = DEPTH-1 sets full and holds wptr at 0.
REQ-017 s_ready = !full; no writes while full.
REQ-018 Swap occurs in the cycle in.vblnk rises (registered previous vblnk low, current high) if full=1 and freeze=0: sel toggles, full clears, valid_trace sets, frame_swapped pulses.
REQ-019 Swap with full=0 or freeze=1 does not happen; back bank keeps content, s_ready stays low while full.
REQ-020 An accepted write in the swap cycle is impossible (full=1 implies s_ready=0).
REQ-021 All out fields (vcount, vsync, vblnk, hcount, hsync, hblnk, rgb) are exactly in.* delayed 2 clk cycles; rgb alone may be replaced.
REQ-022 Column x = hcount - X0 for 0 <= x < DEPTH; row y = (Y0+255) - vcount for Y0 <= vcount <= Y0+255 (y=0 bottom).
REQ-023 Trace channel k lit at (x,y) when valid_trace=1 and min(d[x-1],d[x]) <= y <= max(d[x-1],d[x]) (vertical fill); at x=0 only y = d[0].
REQ-024 d[x-1] comes from a register holding the previous column's read data; no second read port.
REQ-025 Border lit at hcount = X0-1 or X0+DEPTH for Y0-1 <= vcount <= Y0+256, and at vcount = Y0-1 or Y0+256 for X0-1 <= hcount <= X0+DEPTH.
REQ-026 Grid lit inside plot when x mod GRID = 0 or (vcount-Y0) mod GRID = 0.
REQ-027 Colours: ch0 12'hff0, ch1 12'h0ff, ch2 12'hf0f, ch3 12'h0f0, border 12'hfa0, grid 12'h444.
REQ-028 Priority: ch0 > ch1 > ch2 > ch3 > border > grid > delayed in.rgb.
REQ-029 Blanking: when in.hblnk or in.vblnk is high, rgb = 0 regardless of overlay.
REQ-030 Comparisons use 12-bit signed arithmetic; no wrap for hcount < X0.

Reset
REQ-031 On rst high: all out fields 0, s_ready 0 during reset, wptr 0, full 0, sel 0, valid_trace 0, frame_swapped 0, pipeline registers 0; sample memories not cleared.
REQ-032 rst mid-fill discards the partial back bank; first cycle after release s_ready=1, wptr=0.
REQ-033 Before first swap only border, grid and in.rgb are drawn.

Verification
REQ-034 After reset, in.rgb=12'h123 outside plot/border -> out.rgb=12'h123 exactly 2 cycles later, all sync fields matching.
REQ-035 Stream DEPTH words ch0=ramp x, then vblnk rise -> frame_swapped pulse, ch0 diagonal: pixel (X0+10, Y0+245) = 12'hff0.
REQ-036 ch0 samples d[4]=20, d[5]=60 -> column x=5 lit for y=20..60, y=19 and y=61 not lit by ch0.
REQ-037 ch0 and ch1 both =100 at x=7 -> pixel shows 12'hff0 (priority).
REQ-038 Fill back bank, freeze=1 over two vblnk rises -> no swap, s_ready=0; freeze=0 then next vblnk rise -> swap.
REQ-039 Assert rst after 50 words written -> s_ready=1 after release, next DEPTH words needed before full.
